// File: rtl/data_mem_arbiter_if.sv
// rtl/data_mem_arbiter_if.sv - Requester, wipe-control and RAM-port signal bundle for data_mem_arbiter.
interface data_mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              wipe_req;
  logic              wipe_busy;
  logic              wipe_done;

  logic              ex_req;
  logic              ex_we;
  logic [ADDR_W-1:0] ex_addr;
  logic [DATA_W-1:0] ex_wdata;
  logic              ex_gnt;
  logic              ex_rvalid;
  logic [DATA_W-1:0] ex_rdata;

  logic              ds_req;
  logic [ADDR_W-1:0] ds_addr;
  logic              ds_gnt;
  logic              ds_rvalid;
  logic [DATA_W-1:0] ds_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  wipe_req,
    output wipe_busy, wipe_done,
    input  ex_req, ex_we, ex_addr, ex_wdata,
    output ex_gnt, ex_rvalid, ex_rdata,
    input  ds_req, ds_addr,
    output ds_gnt, ds_rvalid, ds_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output wipe_req,
    input  wipe_busy, wipe_done,
    output ex_req, ex_we, ex_addr, ex_wdata,
    input  ex_gnt, ex_rvalid, ex_rdata,
    output ds_req, ds_addr,
    input  ds_gnt, ds_rvalid, ds_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - Data RAM owner: wipe sequencer plus execution/display port arbiter.
// Optional display starvation guard enabled by defining DATA_ARB_STARVE_GUARD_EN.
module data_mem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 256,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               resetn,
  data_mem_arbiter_if.slave  bus
);
  localparam int WCNT_W = ADDR_W + 1;

  typedef enum logic [0:0] {ST_WIPE, ST_IDLE} state_t;

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              wipe_req_q;
  logic              wipe_done_q, wipe_done_d;
  logic              ex_tag_q, ex_tag_d;
  logic              ds_tag_q, ds_tag_d;
  logic              ex_gnt, ds_gnt;
  logic              ds_promote;

  if (DEPTH < 1 || DEPTH > (1 << ADDR_W) || STARVE_MAX < 1) begin : g_param_check
    $error("data_mem_arbiter: DEPTH or STARVE_MAX out of range");
  end

`ifdef DATA_ARB_STARVE_GUARD_EN
  localparam int SCNT_W = $clog2(STARVE_MAX + 1);

  logic [SCNT_W-1:0] scnt_q, scnt_d;

  assign ds_promote = (scnt_q == SCNT_W'(STARVE_MAX));

  // Counts denied display cycles; frozen while the wipe owns the RAM.
  always_comb begin
    scnt_d = scnt_q;
    if (state_q == ST_IDLE) begin
      if (!bus.ds_req || ds_gnt) scnt_d = '0;
      else                       scnt_d = scnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) scnt_q <= '0;
    else         scnt_q <= scnt_d;
  end
`else
  assign ds_promote = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    wcnt_d        = wcnt_q;
    wipe_done_d   = 1'b0;
    ex_gnt        = 1'b0;
    ds_gnt        = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state_q)
      ST_WIPE: begin
        bus.mem_en   = 1'b1;
        bus.mem_we   = 1'b1;
        bus.mem_addr = wcnt_q[ADDR_W-1:0];
        wcnt_d       = wcnt_q + 1'b1;
        if (wcnt_q == WCNT_W'(DEPTH - 1)) begin
          state_d     = ST_IDLE;
          wcnt_d      = '0;
          wipe_done_d = 1'b1;
        end
      end
      default: begin
        ds_gnt = bus.ds_req & (~bus.ex_req | ds_promote);
        ex_gnt = bus.ex_req & ~ds_gnt;
        if (ex_gnt) begin
          bus.mem_en    = 1'b1;
          bus.mem_we    = bus.ex_we;
          bus.mem_addr  = bus.ex_addr;
          bus.mem_wdata = bus.ex_wdata;
        end else if (ds_gnt) begin
          bus.mem_en   = 1'b1;
          bus.mem_addr = bus.ds_addr;
        end
        // Grant still issues this cycle; the wipe takes over from the next one.
        if (bus.wipe_req && !wipe_req_q) state_d = ST_WIPE;
      end
    endcase
  end

  assign ex_tag_d = ex_gnt & ~bus.ex_we;
  assign ds_tag_d = ds_gnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_WIPE;
      wcnt_q      <= '0;
      wipe_req_q  <= 1'b0;
      wipe_done_q <= 1'b0;
      ex_tag_q    <= 1'b0;
      ds_tag_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      wipe_req_q  <= bus.wipe_req;
      wipe_done_q <= wipe_done_d;
      ex_tag_q    <= ex_tag_d;
      ds_tag_q    <= ds_tag_d;
    end
  end

  assign bus.wipe_busy = (state_q == ST_WIPE);
  assign bus.wipe_done = wipe_done_q;
  assign bus.ex_gnt    = ex_gnt;
  assign bus.ds_gnt    = ds_gnt;
  assign bus.ex_rvalid = ex_tag_q;
  assign bus.ds_rvalid = ds_tag_q;
  assign bus.ex_rdata  = bus.mem_rdata;
  assign bus.ds_rdata  = bus.mem_rdata;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - Directed scoreboard bench for data_mem_arbiter with a write-first RAM model.
module tb_data_mem_arbiter;
  logic clk;
  logic resetn;

  data_mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  data_mem_arbiter #(
    .ADDR_W(8), .DATA_W(8), .DEPTH(256), .STARVE_MAX(4)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] ram [256] = '{default: 8'hA5};

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata     <= bus.mem_wdata;
      end else begin
        bus.mem_rdata <= ram[bus.mem_addr];
      end
    end
  end

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] model [256];
  logic [7:0] ex_q [$];
  logic [7:0] ds_q [$];
  logic       ex_pend = 1'b0;
  logic       ds_pend = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
  endtask

  task automatic cyc();
    @(negedge clk);
    check("ex_rvalid", {31'd0, bus.ex_rvalid}, {31'd0, ex_pend});
    if (ex_pend) check("ex_rdata", {24'd0, bus.ex_rdata}, {24'd0, ex_q.pop_front()});
    check("ds_rvalid", {31'd0, bus.ds_rvalid}, {31'd0, ds_pend});
    if (ds_pend) check("ds_rdata", {24'd0, bus.ds_rdata}, {24'd0, ds_q.pop_front()});
    ex_pend = 1'b0;
    ds_pend = 1'b0;
  endtask

  task automatic ex_access(input logic we, input logic [7:0] a, input logic [7:0] d);
    bus.ex_req = 1'b1; bus.ex_we = we; bus.ex_addr = a; bus.ex_wdata = d;
    #1;
    check("ex_gnt", {30'd0, bus.ex_gnt, bus.ds_gnt}, 32'h2);
    check("ex_mem_cmd", {14'd0, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata},
          {14'd0, 1'b1, we, a, d});
    if (we) model[a] = d;
    else begin ex_q.push_back(model[a]); ex_pend = 1'b1; end
    cyc();
    bus.ex_req = 1'b0;
  endtask

  task automatic ds_access(input logic [7:0] a);
    bus.ds_req = 1'b1; bus.ds_addr = a;
    #1;
    check("ds_mem_cmd", {20'd0, bus.ex_gnt, bus.ds_gnt, bus.mem_en, bus.mem_we, bus.mem_addr},
          {20'd0, 1'b0, 1'b1, 1'b1, 1'b0, a});
    ds_q.push_back(model[a]); ds_pend = 1'b1;
    cyc();
    bus.ds_req = 1'b0;
  endtask

  initial begin
    int busy_cnt, done_cnt, gnt_busy, bad_rd, done_at;
    logic found, exp_ds;

    resetn = 1'b0;
    bus.wipe_req = 1'b0; bus.ex_req = 1'b0; bus.ex_we = 1'b0; bus.ex_addr = '0;
    bus.ex_wdata = '0; bus.ds_req = 1'b0; bus.ds_addr = '0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {26'd0, bus.wipe_busy, bus.wipe_done, bus.ex_rvalid, bus.ds_rvalid,
          bus.ex_gnt, bus.ds_gnt}, 32'h20);
    resetn = 1'b1;

    // Reset wipe: addresses 0..255 written with zero on consecutive cycles
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      check("reset_wipe_cmd", {13'd0, bus.wipe_busy, bus.mem_en, bus.mem_we, bus.mem_wdata, bus.mem_addr},
            {13'd0, 1'b1, 1'b1, 1'b1, 8'h00, 8'(i)});
    end
    @(negedge clk);
    check("reset_wipe_done", {30'd0, bus.wipe_done, bus.wipe_busy}, 32'h2);

    // Execution write/read, write-first same-address, wiped cell
    ex_access(1'b1, 8'h05, 8'h2A);
    ex_access(1'b0, 8'h05, 8'h00);
    ex_access(1'b1, 8'h10, 8'h77);
    ex_access(1'b0, 8'h33, 8'h00);
    ex_access(1'b1, 8'h20, 8'h9C);
    ex_access(1'b0, 8'h20, 8'h00);
    ds_access(8'h10);
    ds_access(8'h20);

    // Contention with both requests held
    bus.ex_req = 1'b1; bus.ex_we = 1'b0; bus.ex_addr = 8'h05; bus.ex_wdata = 8'h00;
    bus.ds_req = 1'b1; bus.ds_addr = 8'h10;
`ifdef DATA_ARB_STARVE_GUARD_EN
    for (int i = 0; i < 10; i++) begin
      exp_ds = (i == 4) || (i == 9);
      #1;
      check("guard_gnt", {30'd0, bus.ex_gnt, bus.ds_gnt}, {30'd0, ~exp_ds, exp_ds});
      if (exp_ds) begin ds_q.push_back(model[8'h10]); ds_pend = 1'b1; end
      else begin ex_q.push_back(model[8'h05]); ex_pend = 1'b1; end
      cyc();
    end
    bus.ex_req = 1'b0; bus.ds_req = 1'b0;
`else
    for (int i = 0; i < 20; i++) begin
      #1;
      check("contend_gnt", {30'd0, bus.ex_gnt, bus.ds_gnt}, 32'h2);
      ex_q.push_back(model[8'h05]); ex_pend = 1'b1;
      cyc();
    end
    bus.ex_req = 1'b0;
    #1;
    check("contend_release", {29'd0, bus.ex_gnt, bus.ds_gnt, bus.mem_we}, 32'h2);
    ds_q.push_back(model[8'h10]); ds_pend = 1'b1;
    cyc();
    bus.ds_req = 1'b0;
`endif

    // Wipe edge coincident with a read; wipe_req then held for 1000 cycles
    ex_access(1'b1, 8'h80, 8'h55);
    bus.wipe_req = 1'b1; bus.ex_req = 1'b1; bus.ex_we = 1'b0; bus.ex_addr = 8'h80;
    #1;
    check("wipe_edge_gnt", {30'd0, bus.ex_gnt, bus.wipe_busy}, 32'h2);
    busy_cnt = 0; done_cnt = 0; gnt_busy = 0; bad_rd = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (i == 0)
        check("wipe_first_rvalid", {22'd0, bus.ex_rvalid, bus.ex_rdata, bus.wipe_busy},
              {22'd0, 1'b1, 8'h55, 1'b1});
      else if (bus.ex_rvalid && bus.ex_rdata !== 8'h00) bad_rd++;
      if (bus.wipe_busy) busy_cnt++;
      if (bus.wipe_done) done_cnt++;
      if (bus.wipe_busy && bus.ex_gnt) gnt_busy++;
    end
    check("held_wipe_busy_cycles", busy_cnt, 256);
    check("held_wipe_done_pulses", done_cnt, 1);
    check("held_wipe_grants_busy", gnt_busy, 0);
    check("held_wipe_rdata_zero", bad_rd, 0);
    bus.ex_req = 1'b0; bus.wipe_req = 1'b0;
    @(negedge clk);
    clear_model();

    // Second wipe from a fresh pulse clears previously written data
    ex_access(1'b1, 8'h05, 8'h2A);
    ex_access(1'b0, 8'h05, 8'h00);
    bus.wipe_req = 1'b1;
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      bus.wipe_req = 1'b0;
      if (bus.wipe_busy) busy_cnt++;
      if (bus.wipe_done) done_cnt++;
    end
    check("pulse_wipe_busy_cycles", busy_cnt, 256);
    check("pulse_wipe_done_pulses", done_cnt, 1);
    clear_model();
    ex_access(1'b0, 8'h05, 8'h00);
    ds_access(8'h80);

    // Reset in the middle of a wipe
    bus.wipe_req = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      bus.wipe_req = 1'b0;
      if (bus.wipe_busy && bus.mem_addr == 8'd100) found = 1'b1;
    end
    check("midwipe_reached_100", {31'd0, found}, 32'h1);
    resetn = 1'b0;
    #1;
    check("midwipe_reset_outputs", {18'd0, bus.wipe_busy, bus.wipe_done, bus.mem_addr,
          bus.ex_rvalid, bus.ds_rvalid, bus.ex_gnt, bus.ds_gnt}, {18'd0, 1'b1, 1'b0, 8'h00, 4'h0});
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("midwipe_restart_addr0", {23'd0, bus.wipe_busy, bus.mem_addr}, {23'd0, 1'b1, 8'h00});
    done_at = -1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (i == 1) check("midwipe_restart_addr1", {24'd0, bus.mem_addr}, 32'h1);
      if (bus.wipe_done && done_at < 0) done_at = i;
    end
    check("midwipe_done_cycle", done_at, 256);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Owns the single-port program-data RAM behind the BF machine. It shares that RAM between two requesters: the execution controller (the `+`, `-`, `,` and `.` operations) and the display scanner that reads cells for the hex/VGA readout. It also runs the memory-wipe sequence that clears every cell to zero, both after reset and on request from the controller's hold state. All RAM traffic goes through this block; nothing else drives the RAM pins.

## Interface
- `ADDR_W`, 8: data-pointer/RAM address width.
- `DATA_W`, 8: cell width.
- `DEPTH`, 256: number of cells wiped; must be ≤ 2^ADDR_W.
- `STARVE_MAX`, 4: consecutive denied display cycles before the display is promoted (used only with the guard enabled).

- `clk` in 1: single clock; all state changes on its rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `wipe_req` in 1: wipe request (the controller's WipeData). Level input; only its rising edge is acted on.
- `wipe_busy` out 1: high while a wipe is in progress.
- `wipe_done` out 1: one-cycle pulse when a wipe completes.
- `ex_req` in 1: execution-port request. Held, with `ex_we`, `ex_addr` and `ex_wdata`, until granted.
- `ex_we` in 1: 1 = write, 0 = read.
- `ex_addr` in ADDR_W: execution-port cell address.
- `ex_wdata` in DATA_W: execution-port write data.
- `ex_gnt` out 1: combinational grant; the transaction is issued this cycle.
- `ex_rvalid` out 1: read data valid, one cycle after a read grant.
- `ex_rdata` out DATA_W: read data.
- `ds_req` in 1: display-port read request, held until granted.
- `ds_addr` in ADDR_W: display-port cell address.
- `ds_gnt` out 1: display-port grant (combinational).
- `ds_rvalid` out 1: display read data valid, one cycle after grant.
- `ds_rdata` out DATA_W: display read data.
- `mem_en` out 1: RAM port enable.
- `mem_we` out 1: RAM write enable.
- `mem_addr` out ADDR_W: RAM address.
- `mem_wdata` out DATA_W: RAM write data.
- `mem_rdata` in DATA_W: RAM read data; synchronous RAM with one-cycle read latency.

## Operation
- **States.**
  - `WIPE`: `wipe_busy`=1; drive `mem_en`=1, `mem_we`=1, `mem_addr`=`wcnt`, `mem_wdata`=0; increment `wcnt` every cycle.
  - `WIPE` → `IDLE` after the write at `wcnt`=DEPTH-1. `wipe_done` pulses in the first `IDLE` cycle; `wcnt` returns to 0.
  - `IDLE` → `WIPE` on a rising edge of `wipe_req`, detected against a registered copy of `wipe_req`. A `wipe_req` held high, or re-asserted while in `WIPE`, starts nothing new.
- **Arbitration in `IDLE`** (fixed priority, execution over display):
  - `ex_gnt` = `ex_req`.
  - `ds_gnt` = `ds_req` & !`ex_req`.
  - At most one grant per cycle.
  - No grants in `WIPE`; requesters stall with their request held.
- **RAM command.**
  - The granted port's signals drive `mem_*`; `mem_we`=0 for display grants.
  - With no grant, `mem_en`=0.
- **Read return.**
  - A granted read sets a registered return tag; the matching `*_rvalid` rises the next cycle with `*_rdata` = `mem_rdata`.
  - A write grant produces no `rvalid`.
- **Same-address access.** A read granted in the cycle after a write to the same address returns the new value (write-first RAM).

## Timing
- **Reset values:**
  - state = `WIPE`, `wcnt`=0, `wipe_busy`=1, `wipe_done`=0.
  - `ex_rvalid`=`ds_rvalid`=0, `ex_gnt`=`ds_gnt`=0.
  - `mem_en`=1 and `mem_we`=1 from the first cycle after `resetn` rises.
  - Every reset therefore auto-wipes for DEPTH cycles.
- **Latency:**
  - Request to grant: 0 cycles when uncontended.
  - Read grant to `rvalid`: 1 cycle.
  - Wipe: exactly DEPTH cycles of `wipe_busy`, then the `wipe_done` pulse.
- **Simultaneous events:**
  - A wipe edge in the same cycle as `ex_req`: the request is granted this cycle; the wipe starts next cycle.
  - An `rvalid` owed from the cycle before a wipe still fires during the first `WIPE` cycle.
- **Reset mid-wipe:** state and `wcnt` return to their reset values and the wipe restarts from address 0.
- **Wrap:** `wcnt` is ADDR_W+1 bits wide, so DEPTH = 2^ADDR_W terminates correctly without wrapping.

## Configuration
- **`DATA_ARB_STARVE_GUARD_EN` defined:**
  - `scnt` (clog2(STARVE_MAX+1) bits, reset 0) increments each `IDLE` cycle in which `ds_req`=1 and `ds_gnt`=0.
  - When `scnt`=STARVE_MAX, the display wins the next contended cycle (`ds_gnt`=1, `ex_gnt`=0).
  - `scnt` clears on any `ds_gnt` and whenever `ds_req`=0; it holds during `WIPE`.
- **Undefined:** strict execution priority; `scnt` logic is absent and the display can starve indefinitely.

## Test plan
- **Reset wipe:** release `resetn`, no requests → `mem_we`=1, `mem_wdata`=0 with addresses 0..255 on 256 consecutive cycles; `wipe_done` pulses at cycle 257; `wipe_busy`=0 afterwards.
- **Execution write then read:** `ex_we`=1, addr 0x05, data 0x2A, then a read of 0x05 → `ex_gnt` each cycle; `ex_rvalid` 1 cycle after the read with `ex_rdata`=0x2A.
- **Contention:** `ex_req` and `ds_req` both held, guard undefined → `ds_gnt` stays 0 for 20 cycles; drop `ex_req` → `ds_gnt`=1 that cycle, `ds_rvalid` next cycle.
- **Starvation guard:** same stimulus with `DATA_ARB_STARVE_GUARD_EN`, STARVE_MAX=4 → `ds_gnt`=1 exactly on the 5th contended cycle, then 4 execution grants before the next display grant.
- **Wipe trigger:** `wipe_req` held high 1000 cycles → exactly one wipe of DEPTH cycles; pulse `wipe_req` again after `wipe_done` → a second wipe; afterwards a read of a previously written cell returns 0x00.
- **Reset mid-wipe:** assert `resetn`=0 at `wcnt`=100 → outputs return to reset values immediately; on release the wipe restarts at address 0.
